// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared types for the SPI command bridge.
//   opcode_e : command opcode carried in bits [7:6] of the command byte
//   state_e  : bridge FSM state, exported on the debug 'state' port
//   CMD_*    : bit positions of the command byte fields
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_SETADDR = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_CMD   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WACK  = 3'd3,
        ST_RREQ  = 3'd4,
        ST_RACK  = 3'd5,
        ST_RWAIT = 3'd6,
        ST_DRAIN = 3'd7
    } state_e;

    // Command byte layout: [7:6] opcode, [5] inc, [4:0] burst count - 1
    localparam int CMD_OP_HI  = 7;
    localparam int CMD_OP_LO  = 6;
    localparam int CMD_INC    = 5;
    localparam int CMD_CNT_HI = 4;
    localparam int CMD_CNT_LO = 0;

endpackage

// File: rtl/spi_cmd_bridge.sv
// spi_cmd_bridge: decodes framed SPI command bytes (from an external spi_byte)
// into request/acknowledge bus cycles, with address setup, read/write bursts,
// optional address auto-increment, overrun detection and frame abort.
//
// Ports:
//   sys_clk, reset          clock; asynchronous active-high reset
//   rx_data, rx_valid       received byte and its one-cycle strobe
//   cs_active               SPI chip select (already synchronised)
//   tx_data                 byte to be shifted out on the next SPI byte
//   bus_addr/wdata/we/req   bus request side
//   bus_ack, bus_rdata      bus acknowledge and read data
//   overrun                 sticky flag: byte received while a bus cycle was pending
//   state                   current FSM state (debug)
//
// ADDR_WIDTH must lie in 8..24 and 8*ADDR_BYTES must be >= ADDR_WIDTH.
module spi_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int ADDR_BYTES = 3
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  cs_active,
    output logic [7:0]            tx_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_req,
    input  logic                  bus_ack,
    input  logic [7:0]            bus_rdata,
    output logic                  overrun,
    output logic [2:0]            state
);

    localparam int ACC_W = 8 * ADDR_BYTES;
    localparam int CNT_W = $clog2(ADDR_BYTES + 1);

    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [ACC_W-1:0]        acc_q,     acc_d;
    logic [CNT_W-1:0]        abytes_q,  abytes_d;
    logic [5:0]              rem_q,     rem_d;
    logic                    inc_q,     inc_d;
    logic [7:0]              wdata_q,   wdata_d;
    logic                    we_q,      we_d;
    logic                    req_q,     req_d;
    logic [7:0]              tx_q,      tx_d;
    logic                    overrun_q, overrun_d;
    logic                    cs_q;

    logic    rx_fire;
    logic    ack_fire;
    logic    cs_rise;
    logic    cs_fall;
    opcode_e cmd_op;

    function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(1);
    endfunction

    // Bytes outside a frame are ignored; ack only counts while a request is out.
    assign rx_fire  = rx_valid & cs_active;
    assign ack_fire = bus_ack & req_q;
    assign cs_rise  = cs_active & ~cs_q;
    assign cs_fall  = ~cs_active & cs_q;
    assign cmd_op   = opcode_e'(rx_data[CMD_OP_HI:CMD_OP_LO]);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CMD;
            addr_q    <= '0;
            acc_q     <= '0;
            abytes_q  <= '0;
            rem_q     <= '0;
            inc_q     <= 1'b0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            req_q     <= 1'b0;
            tx_q      <= 8'h00;
            overrun_q <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            abytes_q  <= abytes_d;
            rem_q     <= rem_d;
            inc_q     <= inc_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            req_q     <= req_d;
            tx_q      <= tx_d;
            overrun_q <= overrun_d;
            cs_q      <= cs_active;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        abytes_d  = abytes_q;
        rem_d     = rem_q;
        inc_d     = inc_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        req_d     = req_q;
        tx_d      = tx_q;
        overrun_d = overrun_q;

        if (cs_rise) begin
            overrun_d = 1'b0;
        end
        if (rx_fire && (state_q == ST_WACK || state_q == ST_RACK)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_CMD: begin
                if (rx_fire) begin
                    case (cmd_op)
                        OP_SETADDR: begin
                            abytes_d = CNT_W'(ADDR_BYTES);
                            state_d  = ST_ADDR;
                        end
                        OP_WRITE: begin
                            rem_d   = 6'(rx_data[CMD_CNT_HI:CMD_CNT_LO]) + 6'd1;
                            inc_d   = rx_data[CMD_INC];
                            state_d = ST_WDATA;
                        end
                        OP_READ: begin
                            // Request goes out with the state change so read data
                            // is back before the master clocks the next byte.
                            rem_d   = 6'(rx_data[CMD_CNT_HI:CMD_CNT_LO]) + 6'd1;
                            inc_d   = rx_data[CMD_INC];
                            we_d    = 1'b0;
                            req_d   = 1'b1;
                            state_d = ST_RREQ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    // Shift MSB-first; bits above ADDR_WIDTH fall off at load time.
                    acc_d    = ACC_W'({acc_q, rx_data});
                    abytes_d = abytes_q - CNT_W'(1);
                    if (abytes_q == CNT_W'(1)) begin
                        addr_d  = acc_d[ADDR_WIDTH-1:0];
                        state_d = ST_CMD;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_fire) begin
                    wdata_d = rx_data;
                    we_d    = 1'b1;
                    req_d   = 1'b1;
                    state_d = ST_WACK;
                end
            end
            ST_WACK: begin
                if (ack_fire) begin
                    req_d = 1'b0;
                    rem_d = rem_q - 6'd1;
                    if (inc_q) addr_d = addr_next(addr_q);
                    state_d = (rem_q == 6'd1) ? ST_CMD : ST_WDATA;
                end
            end
            ST_RREQ: begin
                state_d = ST_RACK;
            end
            ST_RACK: begin
                if (ack_fire) begin
                    req_d = 1'b0;
                    tx_d  = bus_rdata;
                    rem_d = rem_q - 6'd1;
                    if (inc_q) addr_d = addr_next(addr_q);
                    state_d = (rem_q == 6'd1) ? ST_CMD : ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (rx_fire) begin
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_RREQ;
                end
            end
            ST_DRAIN: begin
                // Let the outstanding cycle finish without side effects.
                if (ack_fire) begin
                    req_d   = 1'b0;
                    state_d = ST_CMD;
                end
            end
            default: state_d = ST_CMD;
        endcase

        // Frame abort. An ack coinciding with the fall has already completed
        // above (req_d low), so only a still-pending request needs draining.
        if (cs_fall && state_q != ST_DRAIN) begin
            state_d = req_d ? ST_DRAIN : ST_CMD;
        end
    end

    assign tx_data   = tx_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_req   = req_q;
    assign overrun   = overrun_q;
    assign state     = state_q;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
module tb_spi_cmd_bridge;
    import spi_bridge_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cs_active = 1'b0;
    logic [7:0]  tx_data;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_rdata = 8'h00;
    logic        overrun;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus responder controls and access log
    int          ack_delay = 1;
    logic        ack_hold = 1'b0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    logic [7:0]  rd_q[$];
    logic [16:0] log_addr[$];
    logic        log_we[$];
    logic [7:0]  log_wdata[$];

    spi_cmd_bridge #(.ADDR_WIDTH(17), .ADDR_BYTES(3)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cs_active (cs_active),
        .tx_data   (tx_data),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_req   (bus_req),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .overrun   (overrun),
        .state     (state)
    );

    always #5 sys_clk = ~sys_clk;

    // Responder: acks ack_delay negedges after seeing req, logs each acked access.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (bus_req) req_cycles++;
            if (bus_req && !ack_hold && !bus_ack) begin
                if (wait_cnt >= ack_delay) begin
                    bus_ack = 1'b1;
                    bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    log_addr.push_back(bus_addr);
                    log_we.push_back(bus_we);
                    log_wdata.push_back(bus_wdata);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus_ack = 1'b0;
                if (!bus_req || ack_hold) wait_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge sys_clk);
        cs_active = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic frame_end();
        @(negedge sys_clk);
        cs_active = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endtask

    // Waits for the bus request to drop; an expired bound counts as a failure.
    task automatic wait_req_low(input string name, input int bound);
        for (int i = 0; i < bound && bus_req; i++) @(negedge sys_clk);
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_bad++;
            $display("FAIL %s.timeout: bus_req got %b expected 0 within %0d cycles", name, bus_req, bound);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clk);
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset.tx_data: got %h expected 00", tx_data); end
        n_cmp++; if (bus_addr !== 17'h0) begin n_bad++; $display("FAIL reset.bus_addr: got %h expected 00000", bus_addr); end
        n_cmp++; if (bus_wdata !== 8'h00) begin n_bad++; $display("FAIL reset.bus_wdata: got %h expected 00", bus_wdata); end
        n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL reset.bus_we: got %b expected 0", bus_we); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset.bus_req: got %b expected 0", bus_req); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset.overrun: got %b expected 0", overrun); end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL reset.state: got %0d expected 0", state); end
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_set_addr();
        int rc0;
        clear_log();
        rc0 = req_cycles;
        send_byte(8'hC0);
        n_cmp++; if (state !== ST_ADDR) begin n_bad++; $display("FAIL set_addr.state_addr: got %0d expected 1", state); end
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'h00);
        @(negedge sys_clk);
        n_cmp++; if (bus_addr !== 17'h18000) begin n_bad++; $display("FAIL set_addr.bus_addr: got %h expected 18000", bus_addr); end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL set_addr.state: got %0d expected 0", state); end
        n_cmp++; if (req_cycles !== rc0) begin n_bad++; $display("FAIL set_addr.no_req: got %0d req cycles expected %0d", req_cycles, rc0); end
    endtask

    task automatic test_write_burst();
        logic [16:0] exp_addr[3];
        logic [7:0]  exp_data[3];
        exp_addr[0] = 17'h18000; exp_addr[1] = 17'h18001; exp_addr[2] = 17'h18002;
        exp_data[0] = 8'hAA;     exp_data[1] = 8'hBB;     exp_data[2] = 8'hCC;
        clear_log();
        ack_delay = 2;
        send_byte(8'h62);
        for (int k = 0; k < 3; k++) begin
            send_byte(exp_data[k]);
            wait_req_low("write_burst", 50);
        end
        @(negedge sys_clk);
        n_cmp++; if (log_addr.size() !== 3) begin n_bad++; $display("FAIL write_burst.count: got %0d expected 3", log_addr.size()); end
        for (int k = 0; k < 3 && k < log_addr.size(); k++) begin
            n_cmp++; if (log_addr[k] !== exp_addr[k]) begin n_bad++; $display("FAIL write_burst.addr%0d: got %h expected %h", k, log_addr[k], exp_addr[k]); end
            n_cmp++; if (log_wdata[k] !== exp_data[k]) begin n_bad++; $display("FAIL write_burst.data%0d: got %h expected %h", k, log_wdata[k], exp_data[k]); end
            n_cmp++; if (log_we[k] !== 1'b1) begin n_bad++; $display("FAIL write_burst.we%0d: got %b expected 1", k, log_we[k]); end
        end
        n_cmp++; if (bus_addr !== 17'h18003) begin n_bad++; $display("FAIL write_burst.final_addr: got %h expected 18003", bus_addr); end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL write_burst.state: got %0d expected 0", state); end
    endtask

    task automatic test_read(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [16:0] a1, input logic [16:0] a_final, input string name);
        send_byte(8'hC0); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        clear_log();
        ack_delay = 1;
        rd_q.push_back(d0);
        rd_q.push_back(d1);
        send_byte(cmd);
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin n_bad++; $display("FAIL %s.req_latency: got req=%b we=%b expected req=1 we=0", name, bus_req, bus_we); end
        wait_req_low(name, 50);
        n_cmp++; if (tx_data !== d0) begin n_bad++; $display("FAIL %s.tx0: got %h expected %h", name, tx_data, d0); end
        n_cmp++; if (state !== ST_RWAIT) begin n_bad++; $display("FAIL %s.state_rwait: got %0d expected 6", name, state); end
        send_byte(8'h00);
        wait_req_low(name, 50);
        n_cmp++; if (tx_data !== d1) begin n_bad++; $display("FAIL %s.tx1: got %h expected %h", name, tx_data, d1); end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL %s.state: got %0d expected 0", name, state); end
        n_cmp++; if (log_addr.size() !== 2) begin n_bad++; $display("FAIL %s.count: got %0d expected 2", name, log_addr.size()); end
        if (log_addr.size() == 2) begin
            n_cmp++; if (log_addr[0] !== 17'h1FFFF) begin n_bad++; $display("FAIL %s.addr0: got %h expected 1ffff", name, log_addr[0]); end
            n_cmp++; if (log_addr[1] !== a1) begin n_bad++; $display("FAIL %s.addr1: got %h expected %h", name, log_addr[1], a1); end
        end
        n_cmp++; if (bus_addr !== a_final) begin n_bad++; $display("FAIL %s.final_addr: got %h expected %h", name, bus_addr, a_final); end
    endtask

    task automatic test_overrun();
        clear_log();
        ack_delay = 40;
        send_byte(8'h40);
        send_byte(8'h77);
        n_cmp++; if (state !== ST_WACK) begin n_bad++; $display("FAIL overrun.state_wack: got %0d expected 3", state); end
        send_byte(8'h99);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.set: got %b expected 1", overrun); end
        wait_req_low("overrun", 100);
        @(negedge sys_clk);
        n_cmp++; if (log_addr.size() !== 1) begin n_bad++; $display("FAIL overrun.count: got %0d expected 1", log_addr.size()); end
        if (log_addr.size() == 1) begin
            n_cmp++; if (log_wdata[0] !== 8'h77) begin n_bad++; $display("FAIL overrun.wdata: got %h expected 77", log_wdata[0]); end
            n_cmp++; if (log_addr[0] !== 17'h00001) begin n_bad++; $display("FAIL overrun.addr: got %h expected 00001", log_addr[0]); end
        end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL overrun.state: got %0d expected 0", state); end
        frame_end();
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun.sticky: got %b expected 1", overrun); end
        frame_start();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun.clear: got %b expected 0", overrun); end
        ack_delay = 1;
    endtask

    task automatic test_drain();
        clear_log();
        ack_hold = 1'b1;
        rd_q.delete();
        rd_q.push_back(8'hEE);
        send_byte(8'hA0);
        @(negedge sys_clk);
        n_cmp++; if (state !== ST_RACK) begin n_bad++; $display("FAIL drain.state_rack: got %0d expected 5", state); end
        cs_active = 1'b0;
        @(negedge sys_clk);
        n_cmp++; if (state !== ST_DRAIN) begin n_bad++; $display("FAIL drain.state_drain: got %0d expected 7", state); end
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL drain.req_held: got %b expected 1", bus_req); end
        repeat (4) @(negedge sys_clk);
        ack_delay = 0;
        ack_hold = 1'b0;
        wait_req_low("drain", 20);
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL drain.state: got %0d expected 0", state); end
        n_cmp++; if (tx_data !== 8'h22) begin n_bad++; $display("FAIL drain.tx_data: got %h expected 22", tx_data); end
        n_cmp++; if (bus_addr !== 17'h00001) begin n_bad++; $display("FAIL drain.bus_addr: got %h expected 00001", bus_addr); end
        ack_delay = 1;
    endtask

    task automatic test_cs_low_ignored();
        send_byte(8'h40);
        send_byte(8'h12);
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL cs_low.state: got %0d expected 0", state); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL cs_low.bus_req: got %b expected 0", bus_req); end
    endtask

    task automatic test_reset_mid();
        frame_start();
        ack_hold = 1'b1;
        send_byte(8'h40);
        send_byte(8'h55);
        send_byte(8'h66);
        n_cmp++; if (bus_req !== 1'b1 || overrun !== 1'b1) begin n_bad++; $display("FAIL reset_mid.pre: got req=%b ovr=%b expected 1 1", bus_req, overrun); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_mid.bus_req: got %b expected 0", bus_req); end
        n_cmp++; if (bus_addr !== 17'h0) begin n_bad++; $display("FAIL reset_mid.bus_addr: got %h expected 00000", bus_addr); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_mid.overrun: got %b expected 0", overrun); end
        n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL reset_mid.state: got %0d expected 0", state); end
        @(negedge sys_clk);
        reset = 1'b0;
        ack_hold = 1'b0;
        @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        frame_start();
        test_set_addr();
        test_write_burst();
        test_read(8'h81, 8'h5A, 8'hA5, 17'h1FFFF, 17'h1FFFF, "read_noinc");
        test_read(8'hA1, 8'h11, 8'h22, 17'h00000, 17'h00001, "read_inc");
        test_overrun();
        test_drain();
        test_cs_low_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
